uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter. It is the transmit-direction counterpart to the board's uart_rx byte receiver.
- The host logic pushes bytes into an internal FIFO. The block serialises them LSB-first on a single line at a fixed baud rate derived from clk.
- It sits between command/response logic (e.g. echo of mode-control results) and the board TX pin, and owns its own baud timing.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per UART bit (50 MHz / 9600). Minimum 2.
- FIFO_DEPTH, 16, byte entries in the TX FIFO. Power of two, ≥2.
- FIFO_AW, 4, log2(FIFO_DEPTH); pointer width.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  push wr_data into FIFO this cycle
- wr_data  input  8  byte to transmit
- fifo_full  output  1  FIFO holds FIFO_DEPTH bytes
- fifo_empty  output  1  FIFO holds 0 bytes
- overflow  output  1  one-cycle pulse: wr_en while fifo_full (byte dropped)
- busy  output  1  serialiser is in a frame (not IDLE)
- tx  output  1  serial line, idle high

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. All state is sampled on the rising edge of clk, and reset has priority over all other inputs.
- Reset values:
  - tx=1, busy=0, overflow=0
  - fifo_empty=1, fifo_full=0
  - rd/wr pointers=0, count=0
  - state=IDLE, baud counter=0, bit index=0
- FIFO:
  - Circular buffer with FIFO_AW-bit pointers and a (FIFO_AW+1)-bit count.
  - Write is accepted when wr_en=1 and count<FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
  - Write while full: byte discarded, count unchanged, overflow=1 for exactly that cycle.
  - Full is judged on the registered count. A pop in the same cycle does not make room for a write while full.
  - Simultaneous accepted write and pop: count unchanged, both pointers advance.
  - fifo_full and fifo_empty are registered flags derived from the next count.
- Serialiser FSM: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If !fifo_empty: pop head into shift register, clear baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - IDLE lasts ≥1 cycle between frames, so back-to-back frames are separated by exactly 1 extra idle-high clk cycle.
- Baud counter counts 0..CLKS_PER_BIT-1 and is cleared on every state transition.
- tx is registered (glitch-free).
- busy=1 in START/DATA/STOP, 0 in IDLE.
- Latency: a wr_en into an empty FIFO with FSM idle at edge N gives fifo_empty=0 after N, pop at edge N+1, and tx falling at edge N+2.
- Frame length: 10×CLKS_PER_BIT cycles (11× with parity).
- wr_en is ignored while reset=1.
- Reset mid-frame: tx returns to 1 on the next edge, FIFO is flushed, and the partial frame is abandoned (line sees a truncated frame, by design).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: adds state PARITY between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 8E1, 11 bit times.
  - Parity is computed from the popped byte at pop time.
- Undefined: no PARITY state, no parity logic; frame is 8N1.

Test Plan (all with CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted):
- Reset then idle 50 cycles → tx=1, busy=0, fifo_empty=1, fifo_full=0, overflow never 1.
- Single write 0x55 at edge N → tx low at N+2 for 4 cycles; data bits 1,0,1,0,1,0,1,0 each 4 cycles; stop high 4 cycles; busy falls at N+42.
- Write 0xA3, 0x0F on consecutive cycles → two frames, LSB-first 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0; exactly one idle cycle between stop bit and second start bit.
- Write 6 bytes on consecutive cycles while the FSM is idle → 5 accepted (1 popped + 4 stored), fifo_full=1, overflow pulses once on the 6th write; exactly 5 frames emitted in order.
- Assert reset during DATA bit 3 of frame 0xFF with 2 bytes queued → tx=1 next edge, fifo_empty=1, busy=0; no further frames emitted.
- With UART_TX_PARITY_EN defined, send 0x07 → parity bit=1, frame 44 cycles. Send 0x03 → parity bit=0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered 8N1 UART transmitter; defining UART_TX_PARITY_EN adds an even parity bit (8E1).
// Start bit falls 2 clk after a write into an idle, empty block; no backpressure, so writes while full are dropped and flagged on overflow.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       overflow,
  output logic       busy,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]    LAST_BAUD = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } stateT;

  stateT state, stateNext;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wrPtr, rdPtr;
  logic [FIFO_AW:0]   count, countNext;
  logic [CW-1:0]      baudCnt;
  logic [2:0]         bitIdx;
  logic [7:0]         shiftReg;
  logic               accept, pop, bitDone, txNext;
`ifdef UART_TX_PARITY_EN
  logic               parityBit;
`endif

  always_comb begin
    stateNext = state;
    pop       = 1'b0;
    txNext    = 1'b1;
    bitDone   = (baudCnt == LAST_BAUD);
    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    accept    = wr_en && (count != DEPTH_CNT);
    countNext = count;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          stateNext = START;
        end
      end
      START: begin
        txNext = 1'b0;
        if (bitDone) stateNext = DATA;
      end
      DATA: begin
        txNext = shiftReg[0];
        if (bitDone && bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          stateNext = PARITY;
`else
          stateNext = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txNext = parityBit;
        if (bitDone) stateNext = STOP;
      end
`endif
      STOP: begin
        if (bitDone) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (accept && !pop) countNext = count + (FIFO_AW + 1)'(1);
    else if (!accept && pop) countNext = count - (FIFO_AW + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wrPtr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      overflow   <= 1'b0;
      baudCnt    <= '0;
      bitIdx     <= '0;
      shiftReg   <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parityBit  <= 1'b0;
`endif
    end else begin
      state      <= stateNext;
      count      <= countNext;
      fifo_full  <= (countNext == DEPTH_CNT);
      fifo_empty <= (countNext == '0);
      overflow   <= wr_en && !accept;
      // tx and busy follow the registered state one cycle later, keeping the line glitch-free.
      tx         <= txNext;
      busy       <= (state != IDLE);
      if (accept) wrPtr <= wrPtr + FIFO_AW'(1);
      if (pop) begin
        rdPtr    <= rdPtr + FIFO_AW'(1);
        shiftReg <= mem[rdPtr];
`ifdef UART_TX_PARITY_EN
        parityBit <= ^mem[rdPtr];
`endif
      end
      if (stateNext != state || bitDone) baudCnt <= '0;
      else if (state != IDLE) baudCnt <= baudCnt + CW'(1);
      if (state == START) begin
        bitIdx <= '0;
      end else if (state == DATA && bitDone) begin
        shiftReg <= shiftReg >> 1;
        bitIdx   <= bitIdx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a scoreboard queue holds the bytes expected on the line and a monitor decodes each frame.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       fifo_full, fifo_empty, overflow, busy, tx;

  int errors = 0;
  int checks = 0;
  int framesDone = 0;
  int ovfCount = 0;
  int lastGap = 0;
  int framesBefore = 0;
  logic [7:0] expQ [$];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow),
    .busy(busy), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge samples the write.
  task automatic pushByte(input logic [7:0] d, input bit acc);
    wr_en   = 1'b1;
    wr_data = d;
    if (acc) expQ.push_back(d);
    @(negedge clk);
  endtask

  task automatic waitFrames(input int target);
    for (int i = 0; i < 3000 && framesDone < target; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("frames_done", 32'(framesDone), 32'(target));
  endtask

  always @(negedge clk) if (overflow === 1'b1) ovfCount++;

  initial begin : monitor
    logic         prevTx;
    logic [7:0]   b;
    logic [CPB-1:0] samp;
    logic         expBit;
    int           idleRun;
    bit           abort;
    prevTx  = 1'b1;
    idleRun = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prevTx  = 1'b1;
        idleRun = 0;
      end else if (tx === 1'b0 && prevTx === 1'b1) begin
        lastGap = idleRun;
        check("frame_expected", 32'(expQ.size() != 0), 1);
        b = (expQ.size() != 0) ? expQ.pop_front() : 8'h00;
        abort = 1'b0;
        samp = '0;
        for (int k = 0; k < NBITS && !abort; k++) begin
          for (int s = 0; s < CPB; s++) begin
            if (k != 0 || s != 0) @(negedge clk);
            if (reset) begin
              abort = 1'b1;
              break;
            end
            samp[s] = tx;
          end
          if (!abort) begin
            if (k == 0) expBit = 1'b0;
            else if (k <= 8) expBit = b[k-1];
`ifdef UART_TX_PARITY_EN
            else if (k == 9) expBit = ^b;
`endif
            else expBit = 1'b1;
            check($sformatf("frame%0d_bit%0d", framesDone, k), 32'(samp), 32'({CPB{expBit}}));
          end
        end
        if (!abort) framesDone++;
        prevTx  = 1'b1;
        idleRun = 0;
      end else begin
        if (tx === 1'b1) idleRun++;
        prevTx = tx;
      end
    end
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_empty", 32'(fifo_empty), 1);
    check("rst_full", 32'(fifo_full), 0);
    check("rst_overflow", 32'(overflow), 0);
    reset = 1'b0;

    repeat (50) @(negedge clk);
    check("idle_tx", 32'(tx), 1);
    check("idle_busy", 32'(busy), 0);
    check("idle_empty", 32'(fifo_empty), 1);
    check("idle_full", 32'(fifo_full), 0);
    check("idle_no_overflow", 32'(ovfCount), 0);

    // Single byte: latency and busy window.
    pushByte(8'h55, 1'b1);
    wr_en = 1'b0;
    check("lat_empty_n", 32'(fifo_empty), 0);
    @(negedge clk);
    check("lat_tx_n1", 32'(tx), 1);
    @(negedge clk);
    check("lat_tx_n2", 32'(tx), 0);
    check("lat_busy_n2", 32'(busy), 1);
    repeat (FRAME - 1) @(negedge clk);
    check("busy_last_cycle", 32'(busy), 1);
    @(negedge clk);
    check("busy_falls", 32'(busy), 0);
    waitFrames(1);

    // Back-to-back frames with one idle cycle between them.
    pushByte(8'hA3, 1'b1);
    pushByte(8'h0F, 1'b1);
    wr_en = 1'b0;
    waitFrames(3);
    check("b2b_gap", 32'(lastGap), 1);
    check("b2b_empty", 32'(fifo_empty), 1);

    // Fill past capacity: one popped, four stored, sixth dropped.
    pushByte(8'h10, 1'b1);
    pushByte(8'h21, 1'b1);
    pushByte(8'h32, 1'b1);
    pushByte(8'h43, 1'b1);
    pushByte(8'h54, 1'b1);
    check("fill_full", 32'(fifo_full), 1);
    check("fill_no_ovf_yet", 32'(overflow), 0);
    pushByte(8'h65, 1'b0);
    wr_en = 1'b0;
    check("ovf_pulse", 32'(overflow), 1);
    @(negedge clk);
    check("ovf_one_cycle", 32'(overflow), 0);
    check("full_held", 32'(fifo_full), 1);
    waitFrames(8);
    check("ovf_count", 32'(ovfCount), 1);
    check("drain_empty", 32'(fifo_empty), 1);
    check("drain_not_full", 32'(fifo_full), 0);

    // Reset during data bit 3 of 0xFF with two bytes queued.
    pushByte(8'hFF, 1'b1);
    pushByte(8'h11, 1'b0);
    pushByte(8'h22, 1'b0);
    wr_en = 1'b0;
    repeat (16) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_tx", 32'(tx), 1);
    check("midrst_empty", 32'(fifo_empty), 1);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_full", 32'(fifo_full), 0);
    reset = 1'b0;
    framesBefore = framesDone;
    repeat (200) @(negedge clk);
    check("no_frames_after_rst", 32'(framesDone), 32'(framesBefore));
    check("post_rst_tx", 32'(tx), 1);
    check("post_rst_empty", 32'(fifo_empty), 1);

`ifdef UART_TX_PARITY_EN
    pushByte(8'h07, 1'b1);
    wr_en = 1'b0;
    waitFrames(framesBefore + 1);
    pushByte(8'h03, 1'b1);
    wr_en = 1'b0;
    waitFrames(framesBefore + 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
